alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Sequencer that shares the single 16-bit ALU between two requesters: port 0 (execute stage) and port 1 (PC/branch-target unit). It accepts one operation at a time, drives the ALU's opcode and operand inputs from registers, captures the ALU result and flags, and returns them to the winning requester with a one-cycle done pulse. It sits between the pipeline control and the combinational ALU instance.

## Interface
Parameters:
- WIDTH, 16, data width of operands and result
- OPW, 4, opcode width (ALU inst_id)

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high
- req0 / req1  in  1  request from port 0 / port 1
- op0 / op1  in  OPW  opcode from port 0 / 1
- a0, b0 / a1, b1  in  WIDTH  operands from port 0 / 1
- gnt0 / gnt1  out  1  grant; high during the EXEC cycle of that port's operation
- done0 / done1  out  1  one-cycle pulse; result/zero/pos valid for that port
- result  out  WIDTH  captured ALU result
- zero, pos  out  1  captured ALU flags
- busy  out  1  high in EXEC and WB
- alu_op  out  OPW  to ALU inst_id
- alu_in0, alu_in1  out  WIDTH  to ALU operands
- alu_reset  out  1  equals reset (direct connection)
- alu_out  in  WIDTH  from ALU
- alu_zero, alu_pos  in  1  from ALU flags

## Operation
- States: IDLE, EXEC, WB. Reset state is IDLE.
- IDLE: if no req, stay. If any req, select winner, register its op/a/b into alu_op/alu_in0/alu_in1, register the winner id, and go to EXEC.
- Arbitration: if only one req is high, that port wins. If both are high, the port not granted last wins (round-robin). last_winner resets to 1, so port 0 wins the first tie.
- EXEC: gnt of the winner is high. The ALU evaluates combinationally. At the end of the cycle, capture alu_out→result, alu_zero→zero, alu_pos→pos, update last_winner, and go to WB.
- WB: done of the winner is high and busy is high. Requests are ignored. Go to IDLE.
- Opcode is passed through unmodified; the add/subtract decode stays in the ALU. result wraps modulo 2^WIDTH.
- The requester must hold req, op, and operands stable until the clock edge that ends IDLE. It must drop req before the end of WB unless it wants another operation. A req still high in IDLE is a new operation.
- alu_op/alu_in0/alu_in1 hold their last values outside EXEC. result/zero/pos hold until the next capture.
- Reset in any state: go to IDLE. Any in-flight operation is dropped with no done pulse. All outputs return to their reset values.

## Timing
- Reset values: gnt0=gnt1=done0=done1=busy=0; result=0, zero=0, pos=0; alu_op=0, alu_in0=alu_in1=0; last_winner=1.
- All outputs are registered except alu_reset.
- Latency: req sampled at edge E, gnt high in cycle E+1, done and result valid in cycle E+2.
- Throughput: one operation per 3 cycles; back-to-back operations have IDLE between them.
- gnt0 and gnt1 are never both high. done0 and done1 are never both high. At most one gnt or done is high in any cycle.

## Structure
- Shared package alu_pkg holds:
  - WIDTH/OPW defaults
  - the opcode constants (add group 0000, 0100, 0110, 1000, 1001, 1010, 1011; all others subtract)
  - the state encoding IDLE=2'b00, EXEC=2'b01, WB=2'b10
- One natural sub-module: rr_arb2, a two-input round-robin picker. Inputs: req0, req1, last_winner. Outputs: grant index and valid. It is purely combinational.
- The top holds the FSM, the operand/result registers, and last_winner.

## Test plan
- Single add: req0 with op=0000, a0=5, b0=7 → gnt0 at +1, done0 at +2, result=12, zero=0, pos=1; busy high for 2 cycles.
- Subtract to zero: req1 with op=0001, a1=9, b1=9 → gnt1 and done1 only, result=0, zero=1, pos=0.
- Contention: req0 and req1 held high continuously → grants alternate 0,1,0,1 starting with port 0; each op is 3 cycles apart; gnt never overlaps.
- Wrap-around: op=0000, a=16'hFFFF, b=2 → result=16'h0001.
- Reset mid-operation: assert reset during EXEC → no done pulse, all outputs 0, last_winner=1. A following tie grants port 0.
- Late drop: port 0 keeps req high through WB → a second port-0 operation starts from IDLE. No request is seen during WB.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sequencer: default widths, opcode groups
// and the sequencer state encoding.
package alu_pkg;

  localparam int unsigned ALU_WIDTH = 16;
  localparam int unsigned ALU_OPW   = 4;

  // Opcodes the ALU treats as add; every other opcode subtracts.
  localparam logic [3:0] OP_ADD0 = 4'b0000;
  localparam logic [3:0] OP_ADD1 = 4'b0100;
  localparam logic [3:0] OP_ADD2 = 4'b0110;
  localparam logic [3:0] OP_ADD3 = 4'b1000;
  localparam logic [3:0] OP_ADD4 = 4'b1001;
  localparam logic [3:0] OP_ADD5 = 4'b1010;
  localparam logic [3:0] OP_ADD6 = 4'b1011;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    WB   = 2'b10
  } state_t;

  function automatic logic is_add(input logic [3:0] op);
    return (op == OP_ADD0) || (op == OP_ADD1) || (op == OP_ADD2) ||
           (op == OP_ADD3) || (op == OP_ADD4) || (op == OP_ADD5) ||
           (op == OP_ADD6);
  endfunction

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-input round-robin picker: on a tie the port not granted last wins.
module rr_arb2 (
  input  logic req0,
  input  logic req1,
  input  logic last_winner,
  output logic grant,
  output logic valid
);

  always_comb begin
    valid = req0 | req1;
    grant = (req0 && req1) ? ~last_winner : req1;
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two requesters: accept, execute,
// write back, one operation per three cycles.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH,
  parameter int unsigned OPW   = ALU_OPW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic             req1,
  input  logic [OPW-1:0]   op0,
  input  logic [OPW-1:0]   op1,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             done0,
  output logic             done1,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             pos,
  output logic             busy,
  output logic [OPW-1:0]   alu_op,
  output logic [WIDTH-1:0] alu_in0,
  output logic [WIDTH-1:0] alu_in1,
  output logic             alu_reset,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_zero,
  input  logic             alu_pos
);

  state_t state_q, state_d;
  logic   winner_q, last_winner_q;
  logic   win_id, win_valid;
  logic   load, capture;
  logic   gnt0_d, gnt1_d, done0_d, done1_d, busy_d;

  assign alu_reset = reset;

  rr_arb2 u_rr_arb2 (
    .req0        (req0),
    .req1        (req1),
    .last_winner (last_winner_q),
    .grant       (win_id),
    .valid       (win_valid)
  );

  // Next state plus the next values of the registered handshake outputs.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    capture = 1'b0;
    gnt0_d  = 1'b0;
    gnt1_d  = 1'b0;
    done0_d = 1'b0;
    done1_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (win_valid) begin
          state_d = EXEC;
          load    = 1'b1;
          gnt0_d  = ~win_id;
          gnt1_d  = win_id;
        end
      end
      EXEC: begin
        state_d = WB;
        capture = 1'b1;
        done0_d = ~winner_q;
        done1_d = winner_q;
      end
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      done0   <= 1'b0;
      done1   <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt0    <= gnt0_d;
      gnt1    <= gnt1_d;
      done0   <= done0_d;
      done1   <= done1_d;
      busy    <= busy_d;
    end
  end

  // Operand launch on accept; result capture at the end of EXEC.
  always_ff @(posedge clk) begin
    if (reset) begin
      winner_q      <= 1'b0;
      last_winner_q <= 1'b1;
      alu_op        <= '0;
      alu_in0       <= '0;
      alu_in1       <= '0;
      result        <= '0;
      zero          <= 1'b0;
      pos           <= 1'b0;
    end else begin
      if (load) begin
        winner_q <= win_id;
        alu_op   <= win_id ? op1 : op0;
        alu_in0  <= win_id ? a1 : a0;
        alu_in1  <= win_id ? b1 : b0;
      end
      if (capture) begin
        result        <= alu_out;
        zero          <= alu_zero;
        pos           <= alu_pos;
        last_winner_q <= winner_q;
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: a stub ALU plus a transaction-level timeline model
// that predicts every registered output each cycle.
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int unsigned W  = 16;
  localparam int unsigned OW = 4;

  logic          clk = 1'b0;
  logic          reset, req0, req1;
  logic [OW-1:0] op0, op1;
  logic [W-1:0]  a0, b0, a1, b1;
  logic          gnt0, gnt1, done0, done1, zero, pos, busy, alu_reset;
  logic [W-1:0]  result, alu_in0, alu_in1, alu_out;
  logic [OW-1:0] alu_op;
  logic          alu_zero, alu_pos;

  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(W), .OPW(OW)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .op0(op0), .op1(op1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .result(result), .zero(zero), .pos(pos), .busy(busy),
    .alu_op(alu_op), .alu_in0(alu_in0), .alu_in1(alu_in1),
    .alu_reset(alu_reset),
    .alu_out(alu_out), .alu_zero(alu_zero), .alu_pos(alu_pos)
  );

  // Stand-in for the combinational ALU.
  always_comb begin
    alu_out  = is_add(alu_op) ? W'(alu_in0 + alu_in1) : W'(alu_in0 - alu_in1);
    alu_zero = (alu_out == '0);
    alu_pos  = !alu_out[W-1] && (alu_out != '0);
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] ref_alu(input logic [OW-1:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    int unsigned s;
    if (op inside {4'd0, 4'd4, 4'd6, 4'd8, 4'd9, 4'd10, 4'd11}) s = int'(a) + int'(b);
    else s = int'(a) + 65536 - int'(b);
    return W'(s % 65536);
  endfunction

  // Expected-output timeline, indexed by cycle modulo 4.
  bit           t_g0[4], t_g1[4], t_d0[4], t_d1[4], t_busy[4], t_rv[4];
  logic [W-1:0] t_res[4];
  int           cyc = 0;
  int           next_free = 0;
  int           last = 1;
  logic [W-1:0] e_res = '0, e_in0 = '0, e_in1 = '0;
  logic [OW-1:0] e_op = '0;
  logic         e_zero = 1'b0, e_pos = 1'b0;
  int           n_grants = 0;
  int           grant_log[$];

  task automatic clear_slot(input int s);
    t_g0[s] = 0; t_g1[s] = 0; t_d0[s] = 0; t_d1[s] = 0; t_busy[s] = 0; t_rv[s] = 0;
  endtask

  task automatic tick();
    int w, s;
    @(posedge clk);
    cyc++;
    if (reset) begin
      for (int i = 0; i < 4; i++) clear_slot(i);
      next_free = cyc + 1;
      last = 1;
      e_res = '0; e_zero = 1'b0; e_pos = 1'b0;
      e_op = '0; e_in0 = '0; e_in1 = '0;
    end else if (cyc >= next_free && (req0 || req1)) begin
      w = (req0 && req1) ? 1 - last : (req1 ? 1 : 0);
      s = cyc % 4;
      t_g0[s] = (w == 0); t_g1[s] = (w == 1); t_busy[s] = 1;
      s = (cyc + 1) % 4;
      t_d0[s] = (w == 0); t_d1[s] = (w == 1); t_busy[s] = 1; t_rv[s] = 1;
      t_res[s] = (w == 1) ? ref_alu(op1, a1, b1) : ref_alu(op0, a0, b0);
      e_op  = (w == 1) ? op1 : op0;
      e_in0 = (w == 1) ? a1 : a0;
      e_in1 = (w == 1) ? b1 : b0;
      next_free = cyc + 3;
      last = w;
      grant_log.push_back(w);
    end
    s = cyc % 4;
    if (t_rv[s]) begin
      e_res  = t_res[s];
      e_zero = (e_res == '0);
      e_pos  = (e_res != '0) && (e_res < 16'h8000);
    end
    #1;
    chk("gnt0",    32'(gnt0),    32'(t_g0[s]));
    chk("gnt1",    32'(gnt1),    32'(t_g1[s]));
    chk("done0",   32'(done0),   32'(t_d0[s]));
    chk("done1",   32'(done1),   32'(t_d1[s]));
    chk("busy",    32'(busy),    32'(t_busy[s]));
    chk("result",  32'(result),  32'(e_res));
    chk("zero",    32'(zero),    32'(e_zero));
    chk("pos",     32'(pos),     32'(e_pos));
    chk("alu_op",  32'(alu_op),  32'(e_op));
    chk("alu_in0", 32'(alu_in0), 32'(e_in0));
    chk("alu_in1", 32'(alu_in1), 32'(e_in1));
    chk("alu_reset", 32'(alu_reset), 32'(reset));
    clear_slot(s);
  endtask

  task automatic set0(input logic r, input logic [OW-1:0] op, input logic [W-1:0] a,
                      input logic [W-1:0] b);
    req0 = r; op0 = op; a0 = a; b0 = b;
  endtask

  task automatic set1(input logic r, input logic [OW-1:0] op, input logic [W-1:0] a,
                      input logic [W-1:0] b);
    req1 = r; op1 = op; a1 = a; b1 = b;
  endtask

  initial begin
    reset = 1'b1;
    set0(1'b0, '0, '0, '0);
    set1(1'b0, '0, '0, '0);
    tick(); tick();
    chk("rst_result", 32'(result), 32'h0);
    chk("rst_busy",   32'(busy),   32'h0);
    reset = 1'b0;

    // Single add on port 0.
    set0(1'b1, 4'b0000, 16'd5, 16'd7);
    tick();
    set0(1'b0, '0, '0, '0);
    chk("add_gnt0", 32'(gnt0), 32'h1);
    chk("add_busy1", 32'(busy), 32'h1);
    tick();
    chk("add_done0", 32'(done0), 32'h1);
    chk("add_result", 32'(result), 32'd12);
    chk("add_zero", 32'(zero), 32'h0);
    chk("add_pos", 32'(pos), 32'h1);
    chk("add_busy2", 32'(busy), 32'h1);
    tick();
    chk("add_busy3", 32'(busy), 32'h0);

    // Subtract to zero on port 1.
    set1(1'b1, 4'b0001, 16'd9, 16'd9);
    tick();
    set1(1'b0, '0, '0, '0);
    chk("sub_gnt1", 32'(gnt1), 32'h1);
    chk("sub_gnt0", 32'(gnt0), 32'h0);
    tick();
    chk("sub_done1", 32'(done1), 32'h1);
    chk("sub_result", 32'(result), 32'h0);
    chk("sub_zero", 32'(zero), 32'h1);
    chk("sub_pos", 32'(pos), 32'h0);
    tick();

    // Wrap-around.
    set0(1'b1, 4'b0000, 16'hFFFF, 16'd2);
    tick();
    set0(1'b0, '0, '0, '0);
    tick();
    chk("wrap_result", 32'(result), 32'h0001);
    tick();

    // Contention after reset alternates starting with port 0.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    grant_log.delete();
    set0(1'b1, 4'b0100, 16'd100, 16'd1);
    set1(1'b1, 4'b0011, 16'd50, 16'd60);
    for (int i = 0; i < 12; i++) tick();
    chk("cont_count", 32'(grant_log.size()), 32'd4);
    for (int i = 0; i < grant_log.size(); i++) chk("cont_order", 32'(grant_log[i]), 32'(i % 2));
    set0(1'b0, '0, '0, '0);
    set1(1'b0, '0, '0, '0);
    tick(); tick(); tick();

    // Reset during EXEC drops the operation; next tie goes to port 0.
    set1(1'b1, 4'b0000, 16'd3, 16'd4);
    tick();
    chk("mid_gnt1", 32'(gnt1), 32'h1);
    reset = 1'b1;
    set1(1'b0, '0, '0, '0);
    tick();
    chk("mid_done1", 32'(done1), 32'h0);
    chk("mid_result", 32'(result), 32'h0);
    reset = 1'b0;
    set0(1'b1, 4'b0000, 16'd1, 16'd1);
    set1(1'b1, 4'b0000, 16'd2, 16'd2);
    tick();
    chk("tie_gnt0", 32'(gnt0), 32'h1);
    set1(1'b0, '0, '0, '0);
    // Port 0 keeps req high through WB: a second port-0 op follows.
    tick(); tick(); tick();
    chk("late_gnt0", 32'(gnt0), 32'h1);
    set0(1'b0, '0, '0, '0);
    tick(); tick();

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 1500; i++) begin
      reset = ($urandom_range(0, 59) == 0);
      req0  = ($urandom_range(0, 2) != 0);
      req1  = ($urandom_range(0, 2) != 0);
      op0   = OW'($urandom);
      op1   = OW'($urandom);
      a0    = ($urandom_range(0, 7) == 0) ? 16'hFFFF : W'($urandom);
      b0    = W'($urandom);
      a1    = W'($urandom);
      b1    = ($urandom_range(0, 7) == 0) ? a1 : W'($urandom);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
